// File: rtl/sram_bridge.sv
// CPU-side bridge to two asynchronous SRAMs and the CPLD UART. Data accesses take
// priority over fetches; both use WAIT_CYCLES strobe cycles and end in a one-cycle DONE.
module sram_bridge #(
  parameter int unsigned WAIT_CYCLES    = 1,
  parameter logic [31:0] UART_DATA_ADDR = 32'hBFD003F8,
  parameter logic [31:0] UART_STAT_ADDR = 32'hBFD003FC
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        rom_ce,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,

  input  logic        ram_ce,
  input  logic        ram_we,
  input  logic [3:0]  ram_sel,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_data_i,
  output logic [31:0] ram_data_o,

  output logic        stall_o,

  inout  wire  [31:0] base_ram_data,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n,

  inout  wire  [31:0] ext_ram_data,
  output logic [19:0] ext_ram_addr,
  output logic [3:0]  ext_ram_be_n,
  output logic        ext_ram_ce_n,
  output logic        ext_ram_oe_n,
  output logic        ext_ram_we_n,

  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_dataready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);

  typedef enum logic [1:0] {StIdle, StData, StFetch, StDone} state_e;
  typedef enum logic [2:0] {DevNone, DevBase, DevExt, DevUartData, DevUartStat} dev_e;

  localparam logic [2:0] LastCnt = 3'(WAIT_CYCLES - 1);

  function automatic dev_e decode(input logic [31:0] addr);
    if (addr[31:23] == 9'h100) return addr[22] ? DevExt : DevBase;
    if (addr == UART_DATA_ADDR) return DevUartData;
    if (addr == UART_STAT_ADDR) return DevUartStat;
    return DevNone;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rom_data_q, rom_data_d;
  logic [31:0] ram_data_q, ram_data_d;

  logic        last_cyc;
  logic        acc_active;
  logic        acc_we;
  logic [31:0] acc_addr;
  dev_e        dev;
  logic [31:0] rd_word;
  logic        base_drive;
  logic        ext_drive;

  assign last_cyc   = (cnt_q == LastCnt);
  assign acc_active = (state_q == StData) || (state_q == StFetch);
  assign acc_addr   = (state_q == StFetch) ? rom_addr_i : ram_addr_i;
  assign acc_we     = (state_q == StData) && ram_we;
  assign dev        = acc_active ? decode(acc_addr) : DevNone;

  assign base_ram_addr = acc_addr[21:2];
  assign ext_ram_addr  = acc_addr[21:2];

  // The UART shares the BaseRAM data bus; only the low byte matters to it.
  assign base_ram_data = base_drive ? ram_data_i : 32'bz;
  assign ext_ram_data  = ext_drive  ? ram_data_i : 32'bz;

  assign rom_data_o = rom_data_q;
  assign ram_data_o = ram_data_q;

  always_comb begin
    base_ram_ce_n = 1'b1;
    base_ram_oe_n = 1'b1;
    base_ram_we_n = 1'b1;
    base_ram_be_n = 4'hF;
    ext_ram_ce_n  = 1'b1;
    ext_ram_oe_n  = 1'b1;
    ext_ram_we_n  = 1'b1;
    ext_ram_be_n  = 4'hF;
    uart_rdn      = 1'b1;
    uart_wrn      = 1'b1;
    base_drive    = 1'b0;
    ext_drive     = 1'b0;
    unique case (dev)
      DevBase: begin
        base_ram_ce_n = 1'b0;
        if (acc_we) begin
          base_ram_be_n = ~ram_sel;
          base_ram_we_n = 1'b0;
          base_drive    = 1'b1;
        end else begin
          base_ram_be_n = 4'h0;
          base_ram_oe_n = 1'b0;
        end
      end
      DevExt: begin
        ext_ram_ce_n = 1'b0;
        if (acc_we) begin
          ext_ram_be_n = ~ram_sel;
          ext_ram_we_n = 1'b0;
          ext_drive    = 1'b1;
        end else begin
          ext_ram_be_n = 4'h0;
          ext_ram_oe_n = 1'b0;
        end
      end
      DevUartData: begin
        if (acc_we) begin
          uart_wrn   = 1'b0;
          base_drive = 1'b1;
        end else begin
          uart_rdn = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (dev)
      DevBase:     rd_word = base_ram_data;
      DevExt:      rd_word = ext_ram_data;
      DevUartData: rd_word = {24'h0, base_ram_data[7:0]};
      DevUartStat: rd_word = {30'h0, uart_dataready, uart_tbre & uart_tsre};
      default:     rd_word = 32'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rom_data_d = rom_data_q;
    ram_data_d = ram_data_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 3'd0;
        if (ram_ce)      state_d = StData;
        else if (rom_ce) state_d = StFetch;
      end
      StData: begin
        if (last_cyc) begin
          cnt_d   = 3'd0;
          state_d = rom_ce ? StFetch : StDone;
          if (!ram_we) ram_data_d = rd_word;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StFetch: begin
        if (last_cyc) begin
          cnt_d      = 3'd0;
          state_d    = StDone;
          rom_data_d = rd_word;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_o = 1'b0;
    if (rst) begin
      unique case (state_q)
        StIdle:          stall_o = ram_ce | rom_ce;
        StData, StFetch: stall_o = 1'b1;
        default:         stall_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      rom_data_q <= 32'h0;
      ram_data_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_data_q <= rom_data_d;
      ram_data_q <= ram_data_d;
    end
  end

endmodule

// File: tb/tb_sram_bridge.sv
// Scoreboard bench for sram_bridge: SRAM/UART device models, a word-level reference
// memory, directed scenarios followed by randomized mixed transactions.
module tb_sram_bridge;

  localparam int unsigned W = 1;
  localparam logic [31:0] UartData = 32'hBFD003F8;
  localparam logic [31:0] UartStat = 32'hBFD003FC;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        ram_ce;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr_i;
  logic [31:0] ram_data_i;
  logic [31:0] ram_data_o;
  logic        stall_o;
  wire  [31:0] base_ram_data;
  logic [19:0] base_ram_addr;
  logic [3:0]  base_ram_be_n;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  wire  [31:0] ext_ram_data;
  logic [19:0] ext_ram_addr;
  logic [3:0]  ext_ram_be_n;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
  logic        uart_rdn, uart_wrn;
  logic        uart_dataready, uart_tbre, uart_tsre;

  sram_bridge #(
    .WAIT_CYCLES   (W),
    .UART_DATA_ADDR(UartData),
    .UART_STAT_ADDR(UartStat)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_ce        (rom_ce),
    .rom_addr_i    (rom_addr_i),
    .rom_data_o    (rom_data_o),
    .ram_ce        (ram_ce),
    .ram_we        (ram_we),
    .ram_sel       (ram_sel),
    .ram_addr_i    (ram_addr_i),
    .ram_data_i    (ram_data_i),
    .ram_data_o    (ram_data_o),
    .stall_o       (stall_o),
    .base_ram_data (base_ram_data),
    .base_ram_addr (base_ram_addr),
    .base_ram_be_n (base_ram_be_n),
    .base_ram_ce_n (base_ram_ce_n),
    .base_ram_oe_n (base_ram_oe_n),
    .base_ram_we_n (base_ram_we_n),
    .ext_ram_data  (ext_ram_data),
    .ext_ram_addr  (ext_ram_addr),
    .ext_ram_be_n  (ext_ram_be_n),
    .ext_ram_ce_n  (ext_ram_ce_n),
    .ext_ram_oe_n  (ext_ram_oe_n),
    .ext_ram_we_n  (ext_ram_we_n),
    .uart_rdn      (uart_rdn),
    .uart_wrn      (uart_wrn),
    .uart_dataready(uart_dataready),
    .uart_tbre     (uart_tbre),
    .uart_tsre     (uart_tsre)
  );

  always #5 clk = ~clk;

  // Device models: 16-word SRAMs and a UART receive byte.
  logic [31:0] base_mem [16];
  logic [31:0] ext_mem  [16];
  logic [7:0]  uart_rx;

  assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? base_mem[base_ram_addr[3:0]] :
                         (!uart_rdn) ? {24'h0, uart_rx} : 32'bz;
  assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n) ? ext_mem[ext_ram_addr[3:0]] : 32'bz;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!base_ram_ce_n && !base_ram_we_n && !base_ram_be_n[b])
        base_mem[base_ram_addr[3:0]][8*b +: 8] = base_ram_data[8*b +: 8];
      if (!ext_ram_ce_n && !ext_ram_we_n && !ext_ram_be_n[b])
        ext_mem[ext_ram_addr[3:0]][8*b +: 8] = ext_ram_data[8*b +: 8];
    end
  end

  // Strobe observers.
  int          ext_we_cyc = 0, uart_wr_cyc = 0, uart_rd_cyc = 0;
  logic [3:0]  ext_be_seen;
  logic [19:0] ext_addr_seen;
  logic        wr_base_ce_seen;
  logic [7:0]  uart_tx_seen;

  always @(negedge clk) begin
    if (!ext_ram_we_n) begin
      ext_we_cyc++;
      ext_be_seen   = ext_ram_be_n;
      ext_addr_seen = ext_ram_addr;
    end
    if (!uart_wrn) begin
      uart_wr_cyc++;
      wr_base_ce_seen = base_ram_ce_n;
      uart_tx_seen    = base_ram_data[7:0];
    end
    if (!uart_rdn) uart_rd_cyc++;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: word arrays updated by spec rules, plus last visible results.
  typedef struct {
    logic [31:0] rom;
    logic [31:0] ram;
    bit          chk_ram;
    int          stalls;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ref_base [16];
  logic [31:0] ref_ext  [16];
  logic [31:0] last_rom, last_ram;
  bit          ram_known;

  // cat: 0 base, 1 ext, 2 uart data, 3 uart status, other unmapped
  function automatic logic [31:0] gen_addr(input int cat, input int idx);
    logic [31:0] off = 32'(idx) << 2;
    case (cat)
      0: return 32'h8000_0000 | off;
      1: return 32'h8040_0000 | off;
      2: return UartData;
      3: return UartStat;
      default: case (idx % 3)
        0:       return 32'h8080_0000 | off;
        1:       return 32'h0000_1000 | off;
        default: return 32'hBFD0_03F0;
      endcase
    endcase
  endfunction

  // Scoreboard monitor: DONE is the first non-stalled cycle after a stalled run.
  int run = 0;
  bit prev_stall = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      run        = 0;
      prev_stall = 1'b0;
    end else begin
      if (stall_o) run++;
      else if (prev_stall) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_done: got completion, expected none");
        end else begin
          e = sb.pop_front();
          check("stall_cycles", 32'(run), 32'(e.stalls));
          check("rom_data_o", rom_data_o, e.rom);
          if (e.chk_ram) check("ram_data_o", ram_data_o, e.ram);
          check("done_idle_ce_n", {30'h0, base_ram_ce_n, ext_ram_ce_n}, 32'h3);
        end
        run = 0;
      end
      prev_stall = stall_o;
    end
  end

  task automatic do_txn(input bit do_data, input bit we, input int dcat, input int didx,
                        input logic [3:0] sel, input logic [31:0] wdata,
                        input bit do_fetch, input int fcat, input int fidx);
    exp_t e;
    bit   done = 1'b0;
    if (do_data && !we) begin
      case (dcat)
        0:       last_ram = ref_base[didx];
        1:       last_ram = ref_ext[didx];
        2:       last_ram = {24'h0, uart_rx};
        3:       last_ram = {30'h0, uart_dataready, uart_tbre & uart_tsre};
        default: last_ram = 32'h0;
      endcase
      ram_known = 1'b1;
    end
    if (do_data && we) begin
      ram_known = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (sel[b] && dcat == 0) ref_base[didx][8*b +: 8] = wdata[8*b +: 8];
        if (sel[b] && dcat == 1) ref_ext[didx][8*b +: 8]  = wdata[8*b +: 8];
      end
    end
    // Data goes first, so a fetch in the same transaction sees the stored word.
    if (do_fetch) begin
      case (fcat)
        0:       last_rom = ref_base[fidx];
        1:       last_rom = ref_ext[fidx];
        default: last_rom = 32'h0;
      endcase
    end
    e.rom     = last_rom;
    e.ram     = last_ram;
    e.chk_ram = ram_known;
    e.stalls  = (do_data && do_fetch) ? int'(2 * W + 1) : int'(W + 1);
    sb.push_back(e);

    ram_ce     = do_data;
    ram_we     = we;
    ram_sel    = sel;
    ram_addr_i = gen_addr(dcat, didx);
    ram_data_i = wdata;
    rom_ce     = do_fetch;
    rom_addr_i = gen_addr(fcat, fidx);
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk);
      #1;
      if (!stall_o) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL txn_timeout: got no DONE in 40 cycles, expected completion");
    end
    ram_ce = 1'b0;
    rom_ce = 1'b0;
    ram_we = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wr0, rd0;
    rst = 1'b0;
    rom_ce = 1'b0; rom_addr_i = '0;
    ram_ce = 1'b1; ram_we = 1'b0; ram_sel = 4'h0; ram_addr_i = '0; ram_data_i = '0;
    uart_dataready = 1'b0; uart_tbre = 1'b0; uart_tsre = 1'b0; uart_rx = 8'h00;
    for (int i = 0; i < 16; i++) begin
      base_mem[i] = $urandom;
      ext_mem[i]  = $urandom;
      ref_base[i] = base_mem[i];
      ref_ext[i]  = ext_mem[i];
    end
    base_mem[4] = 32'h12345678;
    ref_base[4] = 32'h12345678;
    last_rom = 32'h0; last_ram = 32'h0; ram_known = 1'b1;

    // Reset state, with a request pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", {31'h0, stall_o}, 32'h0);
    check("reset_rom", rom_data_o, 32'h0);
    check("reset_ram", ram_data_o, 32'h0);
    check("reset_strobes", {24'h0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n, ext_ram_ce_n,
                            ext_ram_oe_n, ext_ram_we_n, uart_rdn, uart_wrn}, 32'hFF);
    ram_ce = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Fetch of BaseRAM word 4.
    do_txn(0, 0, 0, 0, 4'h0, 32'h0, 1, 0, 4);

    // Byte store to ExtRAM word 2.
    wr0 = ext_we_cyc;
    do_txn(1, 1, 1, 2, 4'b0010, 32'hAABBCCDD, 0, 0, 0);
    check("ext_we_cycles", 32'(ext_we_cyc - wr0), 32'(W));
    check("ext_be_n", {28'h0, ext_be_seen}, 32'hD);
    check("ext_addr", {12'h0, ext_addr_seen}, 32'h2);
    do_txn(1, 0, 1, 2, 4'h0, 32'h0, 0, 0, 0);

    // Load and fetch together.
    do_txn(1, 0, 0, 5, 4'h0, 32'h0, 1, 0, 6);

    // UART status read has no strobe.
    uart_dataready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b1;
    rd0 = uart_rd_cyc;
    do_txn(1, 0, 3, 0, 4'h0, 32'h0, 0, 0, 0);
    check("stat_no_rdn", 32'(uart_rd_cyc - rd0), 32'h0);

    // UART data write and read.
    wr0 = uart_wr_cyc;
    do_txn(1, 1, 2, 0, 4'hF, 32'h0000_0041, 0, 0, 0);
    check("uart_wr_cycles", 32'(uart_wr_cyc - wr0), 32'(W));
    check("uart_tx_byte", {24'h0, uart_tx_seen}, 32'h41);
    check("uart_wr_base_ce_n", {31'h0, wr_base_ce_seen}, 32'h1);
    uart_rx = 8'hA5;
    rd0 = uart_rd_cyc;
    do_txn(1, 0, 2, 0, 4'h0, 32'h0, 0, 0, 0);
    check("uart_rd_cycles", 32'(uart_rd_cyc - rd0), 32'(W));

    // Reset in the middle of a write to BaseRAM word 7 (kept out of random traffic).
    ram_ce = 1'b1; ram_we = 1'b1; ram_sel = 4'hF;
    ram_addr_i = gen_addr(0, 7); ram_data_i = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    check("abort_we_active", {31'h0, base_ram_we_n}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    ram_ce = 1'b0; ram_we = 1'b0;
    check("abort_we_n", {31'h0, base_ram_we_n}, 32'h1);
    check("abort_stall", {31'h0, stall_o}, 32'h0);
    check("abort_rom", rom_data_o, 32'h0);
    check("abort_ram", ram_data_o, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    last_rom = 32'h0; last_ram = 32'h0; ram_known = 1'b1;
    @(posedge clk);
    #1;

    // Randomized mixed traffic.
    for (int t = 0; t < 80; t++) begin
      bit d, f, we;
      int dc, fc;
      d  = ($urandom_range(0, 9) < 7);
      f  = ($urandom_range(0, 9) < 6);
      if (!d && !f) f = 1'b1;
      we = $urandom_range(0, 1);
      dc = $urandom_range(0, 4);
      fc = $urandom_range(0, 2);
      if (fc == 2) fc = 4;
      uart_rx = 8'($urandom);
      uart_dataready = $urandom_range(0, 1);
      uart_tbre = $urandom_range(0, 1);
      uart_tsre = $urandom_range(0, 1);
      do_txn(d, we, dc, $urandom_range(0, 6), 4'($urandom), $urandom,
             f, fc, $urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
